// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {StIdle, StBeat0, StBeat1, StResp} arb_state_t;

  typedef logic req_id_t;

  localparam int unsigned VEC_BEATS = 2;

  function automatic logic [1:0] id_onehot(req_id_t id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant with a last-grant register (resets to 1 so port 0 wins the first tie).
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] req,
  output logic [1:0] grant,
  output req_id_t    grant_id
);

  req_id_t last_grant_q;

  always_comb begin
    grant_id = req[1];
    if (req == 2'b11) grant_id = ~last_grant_q;
    grant = (enable && (req != 2'b00)) ? id_onehot(grant_id) : 2'b00;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= 1'b1;
    end else if (grant != 2'b00) begin
      last_grant_q <= grant_id;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates two requesters onto a 32-bit, 1-cycle-latency memory; supports 64-bit two-beat access.
module mem_port_arbiter
  import mem_arb_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  rq_valid,
  input  logic [1:0]  rq_we,
  input  logic [1:0]  rq_vec,
  input  logic [31:0] rq_addr0,
  input  logic [31:0] rq_addr1,
  input  logic [63:0] rq_wdata0,
  input  logic [63:0] rq_wdata1,
  output logic [1:0]  rq_ready,
  output logic [1:0]  rsp_valid,
  output logic [63:0] rsp_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam int unsigned DataW = 32 * VEC_BEATS;

  arb_state_t       state_q;
  req_id_t          id_q;
  logic             we_q;
  logic             vec_q;
  logic [31:0]      addr_q;
  logic [DataW-1:0] wdata_q;
  logic [DataW-1:0] rdata_q;

  logic [1:0] grant;
  req_id_t    grant_id;

  rr_arbiter2 u_rr_arbiter2 (
    .clk      (clk),
    .reset    (reset),
    .enable   ((state_q == StIdle) && !reset),
    .req      (rq_valid),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign rq_ready = grant;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      id_q    <= 1'b0;
      we_q    <= 1'b0;
      vec_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant != 2'b00) begin
            id_q    <= grant_id;
            we_q    <= rq_we[grant_id];
            vec_q   <= rq_vec[grant_id];
            addr_q  <= grant_id ? rq_addr1 : rq_addr0;
            wdata_q <= grant_id ? rq_wdata1 : rq_wdata0;
            rdata_q <= '0;
            state_q <= StBeat0;
          end
        end
        StBeat0: state_q <= vec_q ? StBeat1 : StResp;
        StBeat1: begin
          rdata_q[31:0] <= mem_rdata;
          state_q       <= StResp;
        end
        StResp: begin
          if (vec_q) rdata_q[63:32] <= mem_rdata;
          else       rdata_q[31:0]  <= mem_rdata;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // The final read word arrives during RESP, so the response word bypasses it from mem_rdata.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    rsp_valid = 2'b00;
    rsp_rdata = '0;
    busy      = 1'b0;
    if (!reset) begin
      busy = (state_q != StIdle);
      unique case (state_q)
        StIdle: ;
        StBeat0: begin
          mem_addr  = addr_q;
          mem_wdata = wdata_q[31:0];
          mem_we    = we_q;
        end
        StBeat1: begin
          mem_addr  = addr_q + 32'd1;
          mem_wdata = wdata_q[63:32];
          mem_we    = we_q;
        end
        StResp: begin
          rsp_valid = id_onehot(id_q);
          if (!we_q) rsp_rdata = vec_q ? {mem_rdata, rdata_q[31:0]} : {32'h0, mem_rdata};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have no parameters; word-addressed 32-bit memory, fixed read latency of 1 cycle.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 rq_valid[1:0]  in  2  per-requester request; held high until accepted.
REQ-005 rq_we[1:0]  in  2  1 = write, 0 = read.
REQ-006 rq_vec[1:0]  in  2  1 = 64-bit access (two words), 0 = 32-bit scalar.
REQ-007 rq_addr0, rq_addr1  in  32 each  word address per requester.
REQ-008 rq_wdata0, rq_wdata1  in  64 each  write data; scalar uses [31:0].
REQ-009 rq_ready[1:0]  out  2  one-cycle accept pulse to the granted requester.
REQ-010 rsp_valid[1:0]  out  2  one-cycle completion pulse (reads and writes).
REQ-011 rsp_rdata  out  64  read data, valid while rsp_valid is nonzero.
REQ-012 mem_addr  out  32  memory word address.
REQ-013 mem_wdata  out  32  memory write word.
REQ-014 mem_we  out  1  memory write strobe.
REQ-015 mem_rdata  in  32  memory read word, valid the cycle after mem_addr.
REQ-016 busy  out  1  high in any state other than IDLE.

Function
REQ-017 States: IDLE, BEAT0, BEAT1, RESP.
REQ-018 IDLE: if any rq_valid, grant one requester; pulse its rq_ready; latch we/vec/addr/wdata/id; go to BEAT0.
REQ-019 Arbitration: single requester wins outright; if both request, grant the one not granted last (round-robin).
REQ-020 last_grant updates only on grant; reset value 1, so requester 0 wins the first tie.
REQ-021 BEAT0: mem_addr = addr, mem_wdata = wdata[31:0], mem_we = we; next state BEAT1 if vec, else RESP.
REQ-022 BEAT1: mem_addr = addr+1 (mod 2^32, 0xFFFFFFFF wraps to 0), mem_wdata = wdata[63:32], mem_we = we; capture mem_rdata into rdata[31:0]; next state RESP.
REQ-023 RESP: capture mem_rdata into rdata[31:0] (scalar) or rdata[63:32] (vector).
REQ-024 RESP: pulse rsp_valid[id]; rsp_rdata equals the assembled word; next state IDLE.
REQ-025 Scalar reads SHALL return rsp_rdata[63:32] = 0; writes SHALL return rsp_rdata = 0.
REQ-026 mem_we SHALL be 0 in IDLE and RESP; mem_addr and mem_wdata SHALL be 0 in IDLE.
REQ-027 Latency: grant in cycle N gives rsp_valid at N+2 (scalar) or N+3 (vector).
REQ-028 No grant in any state other than IDLE; the earliest next grant is the cycle after RESP.
REQ-029 Requests deasserted before acceptance are dropped without side effects.
REQ-030 At most one bit of rq_ready and of rsp_valid SHALL be high in any cycle.

Reset
REQ-031 While reset is high, all outputs SHALL be driven to 0, state to IDLE and last_grant to 1.
REQ-032 Reset mid-transaction aborts it; rsp_valid is not issued, and mem_we is 0 from the cycle after reset is sampled.

Structure
REQ-033 Package mem_arb_pkg SHALL hold the arb_state_t enum, the requester-id typedef and the VEC_BEATS=2 constant.
REQ-034 Sub-module rr_arbiter2 SHALL implement the two-way round-robin grant and last_grant register.
REQ-035 The datapath and FSM SHALL reside in mem_port_arbiter; no other sub-modules.

Verification
REQ-036 Scalar read: rq0 read addr 0x10, mem holds 0xCAFE0001 -> rq_ready[0] at N, mem_addr 0x10 at N+1, rsp_valid[0] at N+2, rsp_rdata 0x00000000CAFE0001.
REQ-037 Vector write: rq1 write addr 0x20, wdata 0x11112222_33334444 -> mem_we at N+1 (0x20, 0x33334444) and N+2 (0x21, 0x11112222); rsp_valid[1] at N+3.
REQ-038 Tie: both request continuously after reset -> grants alternate 0,1,0,1; each next grant occurs the cycle after RESP.
REQ-039 Wrap: vector read at 0xFFFFFFFF -> second beat mem_addr 0x00000000; rdata upper word comes from address 0.
REQ-040 Reset asserted in BEAT1 of a vector write -> no rsp_valid, mem_we 0 the next cycle, busy 0; the next tie grants requester 0.
